// File: rtl/board_sprite_fetch_pkg.sv
// Shared types and constants for the chess board sprite fetch path.
// Sprite address layout: {white, light square, piece type, pixel 0..3599}.
package board_sprite_fetch_pkg;

  localparam int unsigned SQ_PX      = 60;
  localparam int unsigned BOARD_N    = 8;
  localparam int unsigned BOARD_PX   = SQ_PX * BOARD_N;
  localparam int unsigned SPRITE_PIX = SQ_PX * SQ_PX;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned ADDR_W  = 17;
  localparam int unsigned PIX_W   = 12;
  localparam int unsigned SUB_W   = 6;
  localparam int unsigned POS_W   = 3;
  localparam int unsigned SQ_W    = 6;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned STATE_W = NIB_W * BOARD_N * BOARD_N;

  typedef enum logic [2:0] {
    PIECE_NONE   = 3'd0,
    PIECE_PAWN   = 3'd1,
    PIECE_KNIGHT = 3'd2,
    PIECE_BISHOP = 3'd3,
    PIECE_ROOK   = 3'd4,
    PIECE_QUEEN  = 3'd5,
    PIECE_KING   = 3'd6
  } piece_t;

  typedef struct packed {
    logic             white;
    logic             light;
    logic [2:0]       kind;
    logic [PIX_W-1:0] pix;
  } sprite_addr_t;

  typedef struct packed {
    logic valid;
    logic in_board;
    logic cursor;
  } side_t;

  // Square 0 (top-left) is light; colour alternates with row and column parity.
  function automatic logic light_sq(input logic [POS_W-1:0] row, input logic [POS_W-1:0] col);
    return ~(row[0] ^ col[0]);
  endfunction

endpackage

// File: rtl/board_sprite_fetch.sv
// Raster-order board tracker: counts square/offset without dividers, issues sprite ROM
// addresses and realigns the ROM palette index with its sideband three cycles later.
module board_sprite_fetch
  import board_sprite_fetch_pkg::*;
#(
  parameter int unsigned BOARD_X0 = 80,
  parameter int unsigned BOARD_Y0 = 0
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 PIX_VALID,
  input  logic [COORD_W-1:0]   DrawX,
  input  logic [COORD_W-1:0]   DrawY,
  input  logic [STATE_W-1:0]   BOARD_STATE,
  input  logic [SQ_W-1:0]      CURSOR_SQ,
  input  logic                 CURSOR_EN,
  output logic [ADDR_W-1:0]    SPRITE_ADDR,
  input  logic [IDX_W-1:0]     ROM_DATA,
  output logic                 PIX_VALID_O,
  output logic                 PIX_IN_BOARD,
  output logic [IDX_W-1:0]     PIX_IDX,
  output logic                 PIX_CURSOR
);

  localparam logic [COORD_W-1:0] X_LO    = COORD_W'(BOARD_X0);
  localparam logic [COORD_W-1:0] Y_LO    = COORD_W'(BOARD_Y0);
  localparam logic [COORD_W-1:0] SPAN    = COORD_W'(BOARD_PX);
  localparam logic [SUB_W-1:0]   SUB_MAX = SUB_W'(SQ_PX - 1);
  localparam logic [PIX_W-1:0]   ROW_INC = PIX_W'(SQ_PX);

  logic [SUB_W-1:0] subx_q, subx_d, suby_q, suby_d;
  logic [POS_W-1:0] col_q, col_d, row_q, row_d;
  logic [PIX_W-1:0] row_base_q, row_base_d;
  logic             locked_q, locked_d;
  sprite_addr_t     addr_q, addr_d;
  side_t            sb1_q, sb1_d, sb2_q, sb3_q;
  logic [IDX_W-1:0] pix_idx_q, pix_idx_d;

  logic [COORD_W-1:0] dx, dy;
  logic               x_in, y_in, at_x0, in_board;
  logic [SQ_W-1:0]    sq;
  logic [NIB_W-1:0]   nib;
  logic [PIX_W-1:0]   pixel;

  // Offsets wrap below the origin, so one unsigned compare covers both edges.
  assign dx    = DrawX - X_LO;
  assign dy    = DrawY - Y_LO;
  assign x_in  = dx < SPAN;
  assign y_in  = dy < SPAN;
  assign at_x0 = dx == '0;

  // Square/offset counters, advanced only by visible pixels.
  always_comb begin
    subx_d     = subx_q;
    col_d      = col_q;
    suby_d     = suby_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    locked_d   = locked_q;
    if (PIX_VALID) begin
      if (at_x0 && dy == '0) begin
        subx_d     = '0;
        col_d      = '0;
        suby_d     = '0;
        row_d      = '0;
        row_base_d = '0;
        locked_d   = 1'b1;
      end else if (at_x0 && y_in) begin
        subx_d = '0;
        col_d  = '0;
        if (suby_q == SUB_MAX) begin
          suby_d     = '0;
          row_base_d = '0;
          row_d      = row_q + POS_W'(1);
        end else begin
          suby_d     = suby_q + SUB_W'(1);
          row_base_d = row_base_q + ROW_INC;
        end
      end else if (!at_x0 && x_in) begin
        if (subx_q == SUB_MAX) begin
          subx_d = '0;
          col_d  = col_q + POS_W'(1);
        end else begin
          subx_d = subx_q + SUB_W'(1);
        end
      end
    end
  end

  // Address stage: uses the counters as updated for the current pixel.
  always_comb begin
    in_board = PIX_VALID & x_in & y_in & locked_d;
    sq       = {row_d, col_d};
    nib      = BOARD_STATE[{sq, 2'b00} +: NIB_W];
    pixel    = row_base_d + PIX_W'(subx_d);
    addr_d   = addr_q;
    if (in_board) begin
      addr_d.white = nib[3];
      addr_d.light = light_sq(row_d, col_d);
      addr_d.kind  = nib[2:0];
      addr_d.pix   = pixel;
    end
    sb1_d.valid    = PIX_VALID;
    sb1_d.in_board = in_board;
    sb1_d.cursor   = in_board & CURSOR_EN & (sq == CURSOR_SQ);
    pix_idx_d      = sb2_q.in_board ? ROM_DATA : '0;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      subx_q     <= '0;
      col_q      <= '0;
      suby_q     <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      locked_q   <= 1'b0;
      addr_q     <= '0;
      sb1_q      <= '0;
      sb2_q      <= '0;
      sb3_q      <= '0;
      pix_idx_q  <= '0;
    end else begin
      subx_q     <= subx_d;
      col_q      <= col_d;
      suby_q     <= suby_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      locked_q   <= locked_d;
      addr_q     <= addr_d;
      sb1_q      <= sb1_d;
      sb2_q      <= sb1_q;
      sb3_q      <= sb2_q;
      pix_idx_q  <= pix_idx_d;
    end
  end

  assign SPRITE_ADDR  = addr_q;
  assign PIX_VALID_O  = sb3_q.valid;
  assign PIX_IN_BOARD = sb3_q.in_board;
  assign PIX_CURSOR   = sb3_q.cursor;
  assign PIX_IDX      = pix_idx_q;

endmodule
